// File: rtl/escalonador_busca_pkg.sv
// Shared constants for the search-job sequencer: FSM encodings and default widths.
package escalonador_busca_pkg;

    localparam int ESC_ADDR_WIDTH = 10;
    localparam int ESC_TIMEOUT_W  = 16;
    localparam int ESC_STATE_W    = 4;

    localparam logic [ESC_ADDR_WIDTH-1:0] NO_PATH = {ESC_ADDR_WIDTH{1'b1}};

    localparam logic [ESC_STATE_W-1:0] ST_IDLE      = 4'd0;
    localparam logic [ESC_STATE_W-1:0] ST_LOAD_DST  = 4'd1;
    localparam logic [ESC_STATE_W-1:0] ST_LOAD_SRC  = 4'd2;
    localparam logic [ESC_STATE_W-1:0] ST_WAIT_LOW  = 4'd3;
    localparam logic [ESC_STATE_W-1:0] ST_WAIT_HIGH = 4'd4;
    localparam logic [ESC_STATE_W-1:0] ST_READ      = 4'd5;
    localparam logic [ESC_STATE_W-1:0] ST_CAPTURE   = 4'd6;
    localparam logic [ESC_STATE_W-1:0] ST_STREAM    = 4'd7;
    localparam logic [ESC_STATE_W-1:0] ST_DONE      = 4'd8;

endpackage

// File: rtl/escalonador_busca_fifo.sv
// Synchronous job FIFO holding {fonte, destino} pairs; full/empty flags are registered.
module esc_job_fifo
    import escalonador_busca_pkg::*;
#(
    parameter int WIDTH = 2 * ESC_ADDR_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q;
    logic             push_s, pop_s;

    // A push is refused while full even if a pop happens in the same cycle.
    assign push_s  = push_i && !full_q;
    assign pop_s   = pop_i && !empty_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

    // Next-state pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CNT_W'(DEPTH));
            empty_q  <= (count_d == CNT_W'(0));
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/escalonador_busca.sv
// Job sequencer for the path-search core: loads destino/fonte, waits for gma_pronto,
// then streams the path nodes out on a valid/ready port.
module escalonador_busca
    import escalonador_busca_pkg::*;
#(
    parameter int ADDR_WIDTH     = ESC_ADDR_WIDTH,
    parameter int FIFO_DEPTH     = 4,
    parameter int MAX_PATH_LEN   = 64,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid_in,
    output logic                  job_ready_out,
    input  logic [ADDR_WIDTH-1:0] job_fonte_in,
    input  logic [ADDR_WIDTH-1:0] job_destino_in,
    output logic [ADDR_WIDTH-1:0] core_addr_out,
    output logic                  core_wr_destino_out,
    output logic                  core_wr_fonte_out,
    input  logic                  core_pronto_in,
    output logic [ADDR_WIDTH-1:0] core_rd_addr_out,
    input  logic [ADDR_WIDTH-1:0] core_rd_data_in,
    output logic                  res_valid_out,
    input  logic                  res_ready_in,
    output logic [ADDR_WIDTH-1:0] res_data_out,
    output logic                  res_last_out,
    output logic                  res_erro_out,
    output logic                  busy_out,
    output logic [15:0]           jobs_done_out
);

    localparam int IDX_W = $clog2(MAX_PATH_LEN);
    localparam int TMO_W = ESC_TIMEOUT_W;
    localparam logic [ADDR_WIDTH-1:0] NO_PATH_WORD = {ADDR_WIDTH{1'b1}};
    localparam logic [IDX_W-1:0]      IDX_MAX      = IDX_W'(MAX_PATH_LEN - 1);
    localparam logic [TMO_W-1:0]      TMO_LIMIT    = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [ESC_STATE_W-1:0] state_q, state_d;
    logic [ADDR_WIDTH-1:0]  fonte_q, fonte_d;
    logic [ADDR_WIDTH-1:0]  destino_q, destino_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   wr_dst_q, wr_dst_d;
    logic                   wr_src_q, wr_src_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [ADDR_WIDTH-1:0]  res_data_q, res_data_d;
    logic                   res_valid_q, res_valid_d;
    logic                   res_last_q, res_last_d;
    logic                   res_erro_q, res_erro_d;
    logic [15:0]            jobs_q, jobs_d;

    logic                        fifo_full_s, fifo_empty_s, pop_s;
    logic [2*ADDR_WIDTH-1:0]     fifo_head_s;
    logic [ADDR_WIDTH-1:0]       head_fonte_s, head_destino_s;
    logic                        hit_fonte_s, at_max_s, tmo_expired_s;

    esc_job_fifo #(
        .WIDTH (2 * ADDR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (job_valid_in),
        .pop_i   (pop_s),
        .wdata_i ({job_fonte_in, job_destino_in}),
        .rdata_o (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    assign head_fonte_s   = fifo_head_s[2*ADDR_WIDTH-1:ADDR_WIDTH];
    assign head_destino_s = fifo_head_s[ADDR_WIDTH-1:0];
    assign hit_fonte_s    = (core_rd_data_in == fonte_q);
    assign at_max_s       = (idx_q == IDX_MAX);
    assign tmo_expired_s  = (tmo_q == TMO_LIMIT);

    // Sequencer next-state; every output register is loaded one cycle ahead of its state.
    always_comb begin
        state_d     = state_q;
        fonte_d     = fonte_q;
        destino_d   = destino_q;
        addr_d      = addr_q;
        wr_dst_d    = 1'b0;
        wr_src_d    = 1'b0;
        rd_addr_d   = rd_addr_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        res_last_d  = res_last_q;
        res_erro_d  = res_erro_q;
        jobs_d      = jobs_q;
        pop_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s     = 1'b1;
                    fonte_d   = head_fonte_s;
                    destino_d = head_destino_s;
                    addr_d    = head_destino_s;
                    wr_dst_d  = 1'b1;
                    state_d   = ST_LOAD_DST;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_LOAD_DST: begin
                addr_d   = fonte_q;
                wr_src_d = 1'b1;
                state_d  = ST_LOAD_SRC;
            end
            ST_LOAD_SRC: begin
                tmo_d   = '0;
                state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW, ST_WAIT_HIGH: begin
                // WAIT_LOW discards a pronto left high by the previous job.
                if ((state_q == ST_WAIT_LOW) && !core_pronto_in) begin
                    tmo_d   = '0;
                    state_d = ST_WAIT_HIGH;
                end else if ((state_q == ST_WAIT_HIGH) && core_pronto_in) begin
                    idx_d     = '0;
                    rd_addr_d = '0;
                    state_d   = ST_READ;
                end else if (tmo_expired_s) begin
                    res_data_d  = '0;
                    res_last_d  = 1'b1;
                    res_erro_d  = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = ST_STREAM;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_READ: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                res_valid_d = 1'b1;
                state_d     = ST_STREAM;
                if ((idx_q == '0) && (core_rd_data_in == NO_PATH_WORD)) begin
                    res_data_d = '0;
                    res_last_d = 1'b1;
                    res_erro_d = 1'b1;
                end else begin
                    res_data_d = core_rd_data_in;
                    res_last_d = hit_fonte_s || at_max_s;
                    res_erro_d = !hit_fonte_s && at_max_s;
                    // Prefetch the next index so it can be captured right after the handshake.
                    if (!(hit_fonte_s || at_max_s)) begin
                        rd_addr_d = ADDR_WIDTH'(idx_q + IDX_W'(1));
                    end else begin
                        rd_addr_d = rd_addr_q;
                    end
                end
            end
            ST_STREAM: begin
                if (res_ready_in) begin
                    res_valid_d = 1'b0;
                    if (res_last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_CAPTURE;
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_DONE: begin
                jobs_d  = jobs_q + 16'd1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fonte_q     <= '0;
            destino_q   <= '0;
            addr_q      <= '0;
            wr_dst_q    <= 1'b0;
            wr_src_q    <= 1'b0;
            rd_addr_q   <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            res_erro_q  <= 1'b0;
            jobs_q      <= 16'd0;
        end else begin
            state_q     <= state_d;
            fonte_q     <= fonte_d;
            destino_q   <= destino_d;
            addr_q      <= addr_d;
            wr_dst_q    <= wr_dst_d;
            wr_src_q    <= wr_src_d;
            rd_addr_q   <= rd_addr_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            res_last_q  <= res_last_d;
            res_erro_q  <= res_erro_d;
            jobs_q      <= jobs_d;
        end
    end

    assign job_ready_out       = !fifo_full_s;
    assign core_addr_out       = addr_q;
    assign core_wr_destino_out = wr_dst_q;
    assign core_wr_fonte_out   = wr_src_q;
    assign core_rd_addr_out    = rd_addr_q;
    assign res_valid_out       = res_valid_q;
    assign res_data_out        = res_data_q;
    assign res_last_out        = res_last_q;
    assign res_erro_out        = res_erro_q;
    assign busy_out            = (state_q != ST_IDLE) || !fifo_empty_s;
    assign jobs_done_out       = jobs_q;

endmodule

// File: tb/tb_escalonador_busca.sv
// Directed bench for escalonador_busca with a behavioural path-search core model.
module tb_escalonador_busca;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          job_valid_in;
    logic          job_ready_out;
    logic [AW-1:0] job_fonte_in, job_destino_in;
    logic [AW-1:0] core_addr_out;
    logic          core_wr_destino_out, core_wr_fonte_out;
    logic          core_pronto = 1'b1;
    logic [AW-1:0] core_rd_addr_out;
    logic [AW-1:0] core_rd_data = '0;
    logic          res_valid_out;
    logic          res_ready = 1'b1;
    logic [AW-1:0] res_data_out;
    logic          res_last_out, res_erro_out, busy_out;
    logic [15:0]   jobs_done_out;

    always #5 clk = ~clk;

    escalonador_busca #(
        .ADDR_WIDTH     (AW),
        .FIFO_DEPTH     (4),
        .MAX_PATH_LEN   (64),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .job_valid_in        (job_valid_in),
        .job_ready_out       (job_ready_out),
        .job_fonte_in        (job_fonte_in),
        .job_destino_in      (job_destino_in),
        .core_addr_out       (core_addr_out),
        .core_wr_destino_out (core_wr_destino_out),
        .core_wr_fonte_out   (core_wr_fonte_out),
        .core_pronto_in      (core_pronto),
        .core_rd_addr_out    (core_rd_addr_out),
        .core_rd_data_in     (core_rd_data),
        .res_valid_out       (res_valid_out),
        .res_ready_in        (res_ready),
        .res_data_out        (res_data_out),
        .res_last_out        (res_last_out),
        .res_erro_out        (res_erro_out),
        .busy_out            (busy_out),
        .jobs_done_out       (jobs_done_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Core model. mode 0: table path, 1: destino-idx, 2: no path, 3: pronto never rises.
    int            mode   = 0;
    int            pdelay = 10;
    int            pcnt   = 0;
    logic [AW-1:0] dst_lat = '0;
    logic [AW-1:0] path_mem [0:63];

    always @(posedge clk) begin
        if (core_wr_destino_out) dst_lat <= core_addr_out;
        if (core_wr_fonte_out) begin
            core_pronto <= 1'b0;
            pcnt        <= 0;
        end else if (!core_pronto && mode != 3) begin
            if (pcnt >= pdelay - 1) core_pronto <= 1'b1;
            else                    pcnt <= pcnt + 1;
        end
        case (mode)
            0:       core_rd_data <= path_mem[core_rd_addr_out[5:0]];
            2:       core_rd_data <= {AW{1'b1}};
            default: core_rd_data <= dst_lat - core_rd_addr_out;
        endcase
    end

    typedef struct {
        logic [AW-1:0] data;
        logic          last;
        logic          erro;
        int            cyc;
    } beat_t;

    beat_t         beats[$];
    int            cyc      = 0;
    int            rdy_mode = 0;
    int            src_cyc  = 0;
    int            n_dst    = 0;
    int            n_src    = 0;
    logic          stall    = 1'b0;
    logic [AW-1:0] hold_data;
    logic          hold_last, hold_erro;

    always @(posedge clk) cyc <= cyc + 1;

    // Result sink: drives ready, records accepted beats, checks stall stability and strobes.
    always @(negedge clk) begin
        if (rst) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                checks++;
                if (!res_valid_out || res_data_out !== hold_data ||
                    res_last_out !== hold_last || res_erro_out !== hold_erro) begin
                    errors++;
                    $display("FAIL beat_stable: got v=%0b d=%0d l=%0b e=%0b, expected v=1 d=%0d l=%0b e=%0b",
                             res_valid_out, res_data_out, res_last_out, res_erro_out,
                             hold_data, hold_last, hold_erro);
                end
            end
            case (rdy_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = 1'($urandom_range(0, 1));
                default: res_ready = 1'b0;
            endcase
            if (res_valid_out && res_ready)
                beats.push_back('{res_data_out, res_last_out, res_erro_out, cyc});
            stall     = res_valid_out && !res_ready;
            hold_data = res_data_out;
            hold_last = res_last_out;
            hold_erro = res_erro_out;
            if (core_wr_destino_out) n_dst++;
            if (core_wr_fonte_out) begin
                n_src++;
                src_cyc = cyc;
            end
            if (core_wr_destino_out && core_wr_fonte_out)
                chk("strobes_exclusive", 1, 0);
        end
    end

    task automatic push_job(input logic [AW-1:0] f, input logic [AW-1:0] d, output bit ok);
        bit acc;
        ok = 1'b0;
        @(negedge clk);
        job_valid_in   = 1'b1;
        job_fonte_in   = f;
        job_destino_in = d;
        for (int t = 0; t < 3000 && !ok; t++) begin
            acc = job_ready_out;
            @(posedge clk);
            #1;
            if (acc) ok = 1'b1;
            else     @(negedge clk);
        end
        job_valid_in = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int t;
        t = 0;
        while (!res_valid_out && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk(name, int'(res_valid_out), 1);
    endtask

    function automatic logic [AW-1:0] exp_word(input int m, input logic [AW-1:0] d, input int n);
        case (m)
            0:       return path_mem[n];
            1:       return d - AW'(n);
            default: return '0;
        endcase
    endfunction

    task automatic collect_job(input string name, input logic [AW-1:0] d, input int m,
                               input int len, input logic erro, input bit gap);
        beat_t b;
        int    n, budget, prev;
        bit    done;
        n = 0; budget = 0; prev = 0; done = 1'b0;
        while (!done && budget < 5000) begin
            if (beats.size() > 0) begin
                b = beats.pop_front();
                chk({name, "_data"}, int'(b.data), int'(exp_word(m, d, n)));
                chk({name, "_last"}, int'(b.last), (n == len - 1) ? 1 : 0);
                chk({name, "_erro"}, int'(b.erro), (n == len - 1) ? int'(erro) : 0);
                if (gap && n > 0) chk({name, "_gap"}, b.cyc - prev, 2);
                if (m == 3) begin
                    checks++;
                    if (b.cyc - src_cyc < 100 || b.cyc - src_cyc > 104) begin
                        errors++;
                        $display("FAIL %s_timeout_delay: got %0d cycles, expected 100..104",
                                 name, b.cyc - src_cyc);
                    end
                end
                prev = b.cyc;
                n++;
                if (b.last) done = 1'b1;
            end else begin
                @(negedge clk);
                budget++;
            end
        end
        chk({name, "_beats"}, n, len);
    endtask

    typedef struct {
        logic [AW-1:0] fonte;
        logic [AW-1:0] destino;
        int            mode;
        int            rdy;
        int            len;
        logic          erro;
    } vec_t;

    vec_t vecs[7];
    bit   ok;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{10'd20,  10'd25,  1, 0, 6,  1'b0};
        vecs[1] = '{10'd100, 10'd110, 1, 1, 11, 1'b0};
        vecs[2] = '{10'd3,   10'd8,   2, 0, 1,  1'b1};
        vecs[3] = '{10'd600, 10'd500, 1, 0, 64, 1'b1};
        vecs[4] = '{10'd7,   10'd9,   3, 0, 1,  1'b1};
        vecs[5] = '{10'd40,  10'd41,  1, 0, 2,  1'b0};
        vecs[6] = '{10'd33,  10'd33,  1, 0, 1,  1'b0};
        for (int i = 0; i < 64; i++) path_mem[i] = 10'd0;
        path_mem[0] = 10'd9; path_mem[1] = 10'd7; path_mem[2] = 10'd6; path_mem[3] = 10'd5;

        rst = 1'b1; job_valid_in = 1'b0; job_fonte_in = '0; job_destino_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_job_ready", int'(job_ready_out), 1);
        chk("rst_res_valid", int'(res_valid_out), 0);
        chk("rst_busy", int'(busy_out), 0);
        chk("rst_jobs_done", int'(jobs_done_out), 0);
        chk("rst_strobes", int'({core_wr_destino_out, core_wr_fonte_out}), 0);
        chk("rst_core_addr", int'(core_addr_out), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single job (5,9) with table path 9,7,6,5.
        mode = 0; rdy_mode = 0;
        push_job(10'd5, 10'd9, ok);
        chk("job1_accepted", int'(ok), 1);
        collect_job("job1", 10'd9, 0, 4, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("job1_jobs_done", int'(jobs_done_out), 1);
        chk("job1_idle", int'(busy_out), 0);

        for (int i = 0; i < 7; i++) begin
            mode = vecs[i].mode; rdy_mode = vecs[i].rdy;
            push_job(vecs[i].fonte, vecs[i].destino, ok);
            chk("vec_accepted", int'(ok), 1);
            collect_job($sformatf("vec%0d", i), vecs[i].destino, vecs[i].mode,
                        vecs[i].len, vecs[i].erro, vecs[i].rdy == 0);
            repeat (3) @(negedge clk);
            chk($sformatf("vec%0d_jobs_done", i), int'(jobs_done_out), 2 + i);
        end

        // FIFO fill while the previous job's result is stalled.
        mode = 1; rdy_mode = 2;
        push_job(10'd50, 10'd57, ok);
        wait_valid("fifo_blocker_valid");
        push_job(10'd60, 10'd62, ok);
        push_job(10'd70, 10'd73, ok);
        push_job(10'd80, 10'd81, ok);
        push_job(10'd90, 10'd94, ok);
        chk("fifo_full_ready", int'(job_ready_out), 0);
        chk("fifo_full_busy", int'(busy_out), 1);
        repeat (5) @(negedge clk);
        chk("fifo_still_full", int'(job_ready_out), 0);
        rdy_mode = 0;
        push_job(10'd95, 10'd95, ok);
        chk("fifo_fifth_accepted", int'(ok), 1);
        collect_job("ff0", 10'd57, 1, 8, 1'b0, 1'b1);
        collect_job("ff1", 10'd62, 1, 3, 1'b0, 1'b1);
        collect_job("ff2", 10'd73, 1, 4, 1'b0, 1'b1);
        collect_job("ff3", 10'd81, 1, 2, 1'b0, 1'b1);
        collect_job("ff4", 10'd94, 1, 5, 1'b0, 1'b1);
        collect_job("ff5", 10'd95, 1, 1, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("fifo_jobs_done", int'(jobs_done_out), 14);
        chk("dst_strobe_count", n_dst, 14);
        chk("src_strobe_count", n_src, 14);

        // Reset while a beat is stalled and another job waits in the FIFO.
        mode = 1; rdy_mode = 2;
        push_job(10'd200, 10'd210, ok);
        wait_valid("rst_test_valid");
        push_job(10'd300, 10'd305, ok);
        chk("rst_test_queued", int'(busy_out), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", int'(res_valid_out), 0);
        chk("mid_rst_data", int'(res_data_out), 0);
        chk("mid_rst_last_erro", int'({res_last_out, res_erro_out}), 0);
        chk("mid_rst_job_ready", int'(job_ready_out), 1);
        chk("mid_rst_busy", int'(busy_out), 0);
        chk("mid_rst_jobs_done", int'(jobs_done_out), 0);
        chk("mid_rst_addr", int'(core_addr_out), 0);
        chk("mid_rst_rd_addr", int'(core_rd_addr_out), 0);
        @(negedge clk);
        rst = 1'b0;
        beats.delete();
        rdy_mode = 0;
        repeat (20) @(negedge clk);
        chk("post_rst_busy", int'(busy_out), 0);
        chk("post_rst_no_beats", beats.size(), 0);
        chk("post_rst_no_new_job", n_dst, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
